// File: rtl/demixer_iq_pkg.sv
// Shared LO encoding for the fs/4 IQ mixer and demixer.
// Phase tables and output saturation helper.
package demixer_iq_pkg;

    typedef logic [1:0] lo_t;

    localparam lo_t LO_ZERO = 2'b00;
    localparam lo_t LO_POS  = 2'b01;
    localparam lo_t LO_NEG  = 2'b10;

    // Entry 0 is the rightmost element: I = cos, Q = -sin.
    localparam logic [3:0][1:0] LO_I_TAB = {LO_ZERO, LO_NEG, LO_ZERO, LO_POS};
    localparam logic [3:0][1:0] LO_Q_TAB = {LO_POS, LO_ZERO, LO_NEG, LO_ZERO};

    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] x,
        input int                 dw
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

// File: rtl/demixer_iq_lo_quad_gen.sv
// fs/4 quadrature LO phase generator.
// Phase advances on accepted samples; clear returns it to phase 0.
module lo_quad_gen
    import demixer_iq_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic advance,
    input  logic clear,
    output lo_t  lo_i,
    output lo_t  lo_q
);

    logic [1:0] phase;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            phase <= 2'd0;
        else if (clear)
            phase <= 2'd0;
        else if (advance)
            phase <= phase + 2'd1;
    end

    assign lo_i = LO_I_TAB[phase];
    assign lo_q = LO_Q_TAB[phase];

endmodule

// File: rtl/demixer_iq.sv
// Quadrature downconverter: fs/4 three-level LO mix followed by
// integrate-and-dump decimation over 2^DEC_LOG2 accepted samples.
module demixer_iq
    import demixer_iq_pkg::*;
#(
    parameter int DW       = 15,
    parameter int DEC_LOG2 = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 sync_clear,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] i_o,
    output logic signed [DW-1:0] q_o,
    output logic                 out_valid,
    output lo_t                  lo_i_o,
    output lo_t                  lo_q_o
);

    localparam int AW = DW + 1 + DEC_LOG2;
    localparam int CW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << DEC_LOG2) - 1);

    logic                 accept;
    logic                 first;
    logic                 last;
    logic [CW-1:0]        cnt;
    logic signed [DW:0]   din_ext;
    logic signed [DW:0]   prod_i;
    logic signed [DW:0]   prod_q;
    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sum_i;
    logic signed [AW-1:0] sum_q;
    logic signed [AW-1:0] shf_i;
    logic signed [AW-1:0] shf_q;
    logic signed [DW-1:0] sat_i;
    logic signed [DW-1:0] sat_q;

    function automatic logic signed [DW:0] mix(
        input lo_t                code,
        input logic signed [DW:0] x
    );
        if (code[1])
            return -x;
        else if (code[0])
            return x;
        return '0;
    endfunction

    assign accept = in_valid & ~sync_clear;

    lo_quad_gen u_lo (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (accept),
        .clear   (sync_clear),
        .lo_i    (lo_i_o),
        .lo_q    (lo_q_o)
    );

    // One extra bit so negating the most negative sample cannot wrap.
    assign din_ext = {din[DW-1], din};
    assign prod_i  = mix(lo_i_o, din_ext);
    assign prod_q  = mix(lo_q_o, din_ext);

    assign first = (cnt == '0);
    assign last  = (cnt == LAST);

    assign sum_i = (first ? '0 : acc_i) + AW'(prod_i);
    assign sum_q = (first ? '0 : acc_q) + AW'(prod_q);

    assign shf_i = sum_i >>> DEC_LOG2;
    assign shf_q = sum_q >>> DEC_LOG2;

    assign sat_i = DW'(saturate(32'(shf_i), DW));
    assign sat_q = DW'(saturate(32'(shf_q), DW));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            i_o       <= '0;
            q_o       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sync_clear) begin
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
            end else if (accept) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    i_o       <= sat_i;
                    q_o       <= sat_q;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demixer_iq.sv
// Self-checking bench for demixer_iq: directed vector table, saturation,
// mid-frame reset and randomized traffic against a frame-sum model.
module tb_demixer_iq;

    localparam int DW = 15;
    localparam int N  = 4;

    logic                 clock;
    logic                 reset_n;
    logic                 sync_clear;
    logic                 in_valid;
    logic signed [DW-1:0] din;
    logic signed [DW-1:0] i_o;
    logic signed [DW-1:0] q_o;
    logic                 out_valid;
    logic [1:0]           lo_i_o;
    logic [1:0]           lo_q_o;

    logic                 in_valid0;
    logic signed [DW-1:0] din0;
    logic signed [DW-1:0] i0;
    logic signed [DW-1:0] q0;
    logic                 ov0;
    logic [1:0]           lo_i0;
    logic [1:0]           lo_q0;

    demixer_iq #(.DW(DW), .DEC_LOG2(2)) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sync_clear (sync_clear),
        .in_valid   (in_valid),
        .din        (din),
        .i_o        (i_o),
        .q_o        (q_o),
        .out_valid  (out_valid),
        .lo_i_o     (lo_i_o),
        .lo_q_o     (lo_q_o)
    );

    demixer_iq #(.DW(DW), .DEC_LOG2(0)) u_dut0 (
        .clock      (clock),
        .reset_n    (reset_n),
        .sync_clear (sync_clear),
        .in_valid   (in_valid0),
        .din        (din0),
        .i_o        (i0),
        .q_o        (q0),
        .out_valid  (ov0),
        .lo_i_o     (lo_i0),
        .lo_q_o     (lo_q0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: LO phase, running frame sums, held outputs.
    int m_phase, m_cnt, m_si, m_sq, m_i, m_q;
    bit m_ov;

    typedef struct {
        bit v;
        int d;
        bit c;
        bit ov;
        int ei;
        int eq;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cos_of(input int p);
        case (p)
            0: return 1;
            2: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int nsin_of(input int p);
        case (p)
            1: return -1;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int code_of(input int s);
        if (s > 0) return 1;
        if (s < 0) return 2;
        return 0;
    endfunction

    function automatic int fdiv(input int s, input int n);
        int r;
        r = s / n;
        if ((s % n != 0) && (s < 0)) r = r - 1;
        return r;
    endfunction

    function automatic int clamp(input int x);
        if (x > 16383) return 16383;
        if (x < -16384) return -16384;
        return x;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_si = 0; m_sq = 0;
        m_i = 0; m_q = 0; m_ov = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        m_ov = 0;
        if (c) begin
            m_phase = 0; m_cnt = 0; m_si = 0; m_sq = 0;
        end else if (v) begin
            m_si += d * cos_of(m_phase);
            m_sq += d * nsin_of(m_phase);
            m_phase = (m_phase + 1) % 4;
            m_cnt++;
            if (m_cnt == N) begin
                m_i = clamp(fdiv(m_si, N));
                m_q = clamp(fdiv(m_sq, N));
                m_ov = 1;
                m_cnt = 0; m_si = 0; m_sq = 0;
            end
        end
    endtask

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic apply(input bit v, input int d, input bit c);
        in_valid   = v;
        din        = DW'(d);
        sync_clear = c;
        #1;
        chk("lo_i", int'(lo_i_o), code_of(cos_of(m_phase)));
        chk("lo_q", int'(lo_q_o), code_of(nsin_of(m_phase)));
        @(posedge clock);
        model_step(v, d, c);
        #1;
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("i_o", int'(i_o), m_i);
        chk("q_o", int'(q_o), m_q);
    endtask

    function automatic void add(input bit v, input int d, input bit c,
                                input bit ov, input int ei, input int eq);
        vec_t e;
        e.v = v; e.d = d; e.c = c; e.ov = ov; e.ei = ei; e.eq = eq;
        tab.push_back(e);
    endfunction

    int pulses;

    initial begin
        reset_n = 1'b1; sync_clear = 1'b0; in_valid = 1'b0; din = '0;
        in_valid0 = 1'b0; din0 = '0;
        model_reset();

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_i", int'(i_o), 0);
        chk("rst_q", int'(q_o), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_lo_i", int'(lo_i_o), 1);
        chk("rst_lo_q", int'(lo_q_o), 0);
        @(posedge clock); @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock); #1;

        // Cosine frame
        add(1, 1000, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, -1000, 0, 0, 0, 0);
        add(1, 0, 0, 1, 500, 0);
        // Sine frames, back to back
        for (int k = 0; k < 2; k++) begin
            add(1, 0, 0, 0, k ? 0 : 500, k ? -500 : 0);
            add(1, 1000, 0, 0, k ? 0 : 500, k ? -500 : 0);
            add(1, 0, 0, 0, k ? 0 : 500, k ? -500 : 0);
            add(1, -1000, 0, 1, 0, -500);
        end
        // Cosine frame with gaps
        add(1, 1000, 0, 0, 0, -500);
        add(0, 77, 0, 0, 0, -500);
        add(1, 0, 0, 0, 0, -500);
        add(0, 5, 0, 0, 0, -500);
        add(1, -1000, 0, 0, 0, -500);
        add(0, -9, 0, 0, 0, -500);
        add(1, 0, 0, 1, 500, 0);
        add(0, 0, 0, 0, 500, 0);
        // Partial frame, then sync_clear discarding a presented sample
        add(1, 1000, 0, 0, 500, 0);
        add(1, 0, 0, 0, 500, 0);
        add(1, 1000, 1, 0, 500, 0);
        add(1, 1000, 0, 0, 500, 0);
        add(1, 0, 0, 0, 500, 0);
        add(1, -1000, 0, 0, 500, 0);
        add(1, 0, 0, 1, 500, 0);
        // Truncation toward -inf
        add(1, -3, 0, 0, 500, 0);
        add(1, 0, 0, 0, 500, 0);
        add(1, 0, 0, 0, 500, 0);
        add(1, 0, 0, 1, -1, 0);

        foreach (tab[k]) begin
            apply(tab[k].v, tab[k].d, tab[k].c);
            chk($sformatf("vec%0d_ov", k), int'(out_valid), int'(tab[k].ov));
            chk($sformatf("vec%0d_i", k), int'(i_o), tab[k].ei);
            chk($sformatf("vec%0d_q", k), int'(q_o), tab[k].eq);
        end

        // Saturation with DEC_LOG2=0: phase 2 negates -16384
        in_valid = 1'b0;
        begin
            int sv[4];
            sv = '{0, 0, -16384, -16384};
            for (int k = 0; k < 4; k++) begin
                in_valid0 = 1'b1;
                din0 = DW'(sv[k]);
                @(posedge clock); #1;
                chk($sformatf("d0_ov%0d", k), int'(ov0), 1);
                if (k == 2) begin
                    chk("d0_sat_i", int'(i0), 16383);
                    chk("d0_sat_q", int'(q0), 0);
                end
                if (k == 3) begin
                    chk("d0_neg_i", int'(i0), 0);
                    chk("d0_neg_q", int'(q0), -16384);
                end
            end
            in_valid0 = 1'b0;
        end

        // Mid-frame asynchronous reset after 3 accepted samples
        apply(1, 1000, 0);
        apply(1, 0, 0);
        apply(1, -1000, 0);
        in_valid = 1'b0;
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        chk("mrst_i", int'(i_o), 0);
        chk("mrst_q", int'(q_o), 0);
        chk("mrst_ov", int'(out_valid), 0);
        chk("mrst_lo_i", int'(lo_i_o), 1);
        chk("mrst_lo_q", int'(lo_q_o), 0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        pulses = 0;
        begin
            int fv[4];
            fv = '{1000, 0, -1000, 0};
            for (int k = 0; k < 4; k++) begin
                apply(1, fv[k], 0);
                pulses += int'(out_valid);
            end
        end
        chk("mrst_pulses", pulses, 1);
        chk("mrst_i_after", int'(i_o), 500);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            bit v, c;
            int d;
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(39) == 0);
            d = int'($urandom_range(32767)) - 16384;
            if ($urandom_range(9) == 0) d = -16384;
            apply(v, d, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
